mac3_stream: RTL

Parametrised streaming multiply-accumulate over consecutive valid samples: three back-to-back `validi` samples a, b, c produce `data_out = a*b + c`, and every further consecutive valid sample slides the window and produces a new result. It extends the fixed 8-bit three-sample MAC with configurable width, a selectable overflow mode (wrap/saturate), an overflow flag and a sliding window. It sits between a sample-stream source and downstream logic that consumes `valido`/`data_out`.

---
 rtl/mac3_pkg.sv | 14 +
 rtl/mac3_arith.sv | 33 +++
 rtl/mac3_stream.sv | 100 ++++++++++
 3 files changed

// File: rtl/mac3_pkg.sv
// Shared types and constants for the mac3_stream sliding-window multiply-accumulate.
package mac3_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GOT1 = 2'd1,
      GOT2 = 2'd2,
      RUN  = 2'd3
   } mac3_state_t;

   localparam int MAC3_WRAP = 0;
   localparam int MAC3_SAT  = 1;

endpackage

// File: rtl/mac3_arith.sv
// Combinational a*b+c at full precision, reduced to W bits by wrap or saturate.
module mac3_arith
   import mac3_pkg::*;
#(
   parameter int W        = 8,
   parameter int SATURATE = MAC3_WRAP
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [W-1:0] c_i,
   output logic [W-1:0] res_o,
   output logic         ovf_o
);

   localparam int FW = 2*W + 1;

   logic [FW-1:0] full;
   logic          ovf;

   function automatic logic [W-1:0] reduce(input logic [FW-1:0] v, input logic over);
      if (SATURATE == MAC3_SAT && over) begin
         reduce = '1;
      end else begin
         reduce = v[W-1:0];
      end
   endfunction

   assign full  = FW'(a_i) * FW'(b_i) + FW'(c_i);
   assign ovf   = |full[FW-1:W];
   assign res_o = reduce(full, ovf);
   assign ovf_o = ovf;

endmodule

// File: rtl/mac3_stream.sv
// Streaming MAC: three consecutive valid samples a, b, c yield a*b+c; the window then slides one sample per cycle.
module mac3_stream
   import mac3_pkg::*;
#(
   parameter int W        = 8,
   parameter int SATURATE = MAC3_WRAP
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         validi,
   input  logic [W-1:0] data_in,
   output logic         valido,
   output logic [W-1:0] data_out,
   output logic         ovf
);

   mac3_state_t  state_q, state_d;
   logic [W-1:0] s_old_q, s_old_d;
   logic [W-1:0] s_mid_q, s_mid_d;
   logic         valido_q, valido_d;
   logic [W-1:0] data_q, data_d;
   logic         ovf_q, ovf_d;

   logic [W-1:0] arith_res;
   logic         arith_ovf;

   mac3_arith #(
      .W        (W),
      .SATURATE (SATURATE)
   ) u_arith (
      .a_i   (s_old_q),
      .b_i   (s_mid_q),
      .c_i   (data_in),
      .res_o (arith_res),
      .ovf_o (arith_ovf)
   );

   always_comb begin
      state_d  = state_q;
      s_old_d  = s_old_q;
      s_mid_d  = s_mid_q;
      valido_d = 1'b0;
      data_d   = data_q;
      ovf_d    = ovf_q;
      // Any gap drops back to IDLE; stale window contents are overwritten before reuse.
      case (state_q)
         IDLE: begin
            if (validi) begin
               s_mid_d = data_in;
               state_d = GOT1;
            end
         end
         GOT1: begin
            if (validi) begin
               s_old_d = s_mid_q;
               s_mid_d = data_in;
               state_d = GOT2;
            end else begin
               state_d = IDLE;
            end
         end
         GOT2, RUN: begin
            if (validi) begin
               valido_d = 1'b1;
               data_d   = arith_res;
               ovf_d    = arith_ovf;
               s_old_d  = s_mid_q;
               s_mid_d  = data_in;
               state_d  = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         s_old_q  <= '0;
         s_mid_q  <= '0;
         valido_q <= 1'b0;
         data_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         s_old_q  <= s_old_d;
         s_mid_q  <= s_mid_d;
         valido_q <= valido_d;
         data_q   <= data_d;
         ovf_q    <= ovf_d;
      end
   end

   assign valido   = valido_q;
   assign data_out = data_q;
   assign ovf      = ovf_q;

endmodule
